// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding and bus direction constants.
// Used by the I2C controller and by i2c_target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } TGT_STATE_ENUM;

    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line: 2-flop synchronizer, optional stability filter, rise/fall pulses.
// Define I2C_TGT_FILTER_EN to accept a level only after FILTER_LEN equal samples.
module i2c_line_sync #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

`ifdef I2C_TGT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q, sync_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             level;

    // NOTE: every variable gets its default before any branch, so no path infers a latch.
    always_comb begin
        sync_d = {sync_q[0], line_i};
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) filt_d = sync_q[1];
            else                                 cnt_d  = cnt_q + 1'b1;
        end
        level  = FILTER_EN ? filt_q : sync_q[1];
        prev_d = level;
    end

    // NOTE: registers use non-blocking assignments only; they reset to 1 because an idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target FSM: address match, write bytes out on rx_valid, read bytes in via tx_req.
// Input filtering is enabled with I2C_TGT_FILTER_EN (see i2c_line_sync).
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       I2C_SCL_t,
    inout  wire        I2C_SDA_t,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       stop_det
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .line_i(I2C_SCL_t),
        .level_o(scl_level), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .line_i(I2C_SDA_t),
        .level_o(sda_level), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start_cond = sda_fall & scl_level;
    assign stop_cond  = sda_rise & scl_level;

    TGT_STATE_ENUM state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d, first_q, first_d, sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d, busy_q, busy_d, stop_det_q, stop_det_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        first_d    = first_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        tx_req_d   = 1'b0;
        stop_det_d = 1'b0;

        // Bus conditions win over any bit-level activity, which aborts a partial byte.
        if (stop_cond) begin
            state_d    = IDLE;
            cnt_d      = '0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else if (start_cond) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[6:0], sda_level};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (sr_q[7:1] == TARGET_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = sr_q[0];
                            first_d  = 1'b1;
                        end else begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        if (rw_q == I2C_RW_READ) begin
                            state_d  = TX_BYTE;
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        sr_d = {sr_q[6:0], sda_level};
                        if (cnt_q == 4'd7) begin
                            state_d    = RX_ACK;
                            cnt_d      = '0;
                            rx_data_d  = {sr_q[6:0], sda_level};
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                RX_ACK: begin
                    // First fall starts the ACK bit, second fall ends it.
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            sda_oe_d = 1'b1;
                            cnt_d    = 4'd1;
                        end else begin
                            state_d  = RX_BYTE;
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end
                    end
                end
                TX_BYTE: begin
                    if (tx_req_q) begin
                        sr_d     = tx_data;
                        sda_oe_d = ~tx_data[7];
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d  = TX_ACK;
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end else begin
                            sr_d     = {sr_q[6:0], 1'b1};
                            sda_oe_d = ~sr_q[6];
                        end
                    end
                end
                TX_ACK: begin
                    // The controller's ACK/NACK is shifted into sr_q[0] on the 9th rise.
                    if (scl_rise) begin
                        sr_d = {sr_q[6:0], sda_level};
                    end else if (scl_fall) begin
                        if (sr_q[0]) begin
                            state_d = WAIT_STOP;
                        end else begin
                            state_d  = TX_BYTE;
                            tx_req_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            stop_det_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            tx_req_q   <= tx_req_d;
            stop_det_q <= stop_det_d;
        end
    end

    assign I2C_SDA_t = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on an open-drain bus with pull-up.
// Glitch expectations follow I2C_TGT_FILTER_EN.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       tb_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, tx_req, busy, stop_det;

    int         n_chk = 0;
    int         n_err = 0;
    int         tx_cnt = 0, stop_cnt = 0, both_cnt = 0;
    logic       busy_seen = 1'b0, dut_low_seen = 1'b0;
    logic [8:0] rx_q[$];
    logic       ack;
    logic [7:0] rd;

    pullup (sda_bus);
    assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk(clk), .rst_n(rst_n), .I2C_SCL_t(scl), .I2C_SDA_t(sda_bus),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .stop_det(stop_det)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) rx_q.push_back({rx_first, rx_data});
            if (tx_req) tx_cnt++;
            if (stop_det) stop_cnt++;
            if (rx_valid && stop_det) both_cnt++;
            if (busy) busy_seen = 1'b1;
            if (!sda_bus && !tb_sda_low) dut_low_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        tx_cnt = 0; stop_cnt = 0; both_cnt = 0;
        busy_seen = 1'b0; dut_low_seen = 1'b0;
    endtask

    task automatic i2c_bit(input logic b, input logic glitch, output logic r);
        wait_clk(Q); tb_sda_low = ~b;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q);
        if (glitch) begin
            scl = 1'b0; wait_clk(1); scl = 1'b1;
        end
        wait_clk(Q);
        r = sda_bus;
        scl = 1'b0;
    endtask

    task automatic i2c_byte(input logic [7:0] b, input int glitch_idx, output logic [7:0] r);
        logic bit_r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(b[i], i == glitch_idx, bit_r);
            r[i] = bit_r;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        logic [7:0] unused_r;
        i2c_byte(b, -1, unused_r);
        i2c_bit(1'b1, 1'b0, a);
    endtask

    task automatic i2c_start();
        wait_clk(Q); tb_sda_low = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); tb_sda_low = 1'b1;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); tb_sda_low = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); tb_sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    initial begin
        #800000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_first", rx_first, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stop_det", stop_det, 1'b0);
        check("rst_sda", sda_bus, 1'b1);

        // Write 0x42/W, A5, 3C, STOP
        clear_mon();
        i2c_start();
        write_byte(8'h84, ack); check("w_addr_ack", ack, 1'b0);
        check("w_busy_set", busy, 1'b1);
        write_byte(8'hA5, ack); check("w_d0_ack", ack, 1'b0);
        write_byte(8'h3C, ack); check("w_d1_ack", ack, 1'b0);
        i2c_stop();
        check("w_rx_count", rx_q.size(), 2);
        check("w_rx0", rx_q[0], {1'b1, 8'hA5});
        check("w_rx1", rx_q[1], {1'b0, 8'h3C});
        check("w_stop_count", stop_cnt, 1);
        check("w_busy_clr", busy, 1'b0);
        check("w_rx_stop_overlap", both_cnt, 0);

        // Wrong address 0x43/W
        clear_mon();
        i2c_start();
        write_byte(8'h86, ack); check("na_addr_nack", ack, 1'b1);
        write_byte(8'hA5, ack); check("na_data_nack", ack, 1'b1);
        i2c_stop();
        check("na_rx_count", rx_q.size(), 0);
        check("na_sda_driven", dut_low_seen, 1'b0);
        check("na_busy_seen", busy_seen, 1'b0);

        // Read 0x42/R: 96 with ACK, 0F with NACK
        clear_mon();
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'h85, ack); check("r_addr_ack", ack, 1'b0);
        i2c_byte(8'hFF, -1, rd); check("r_byte0", rd, 8'h96);
        tx_data = 8'h0F;
        i2c_bit(1'b0, 1'b0, ack);
        i2c_byte(8'hFF, -1, rd); check("r_byte1", rd, 8'h0F);
        i2c_bit(1'b1, 1'b0, ack);
        wait_clk(Q);
        check("r_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
        i2c_stop();
        check("r_idle", 32'(dut.state_q), 32'(IDLE));
        check("r_tx_req_count", tx_cnt, 2);
        check("r_stop_count", stop_cnt, 1);
        check("r_busy_clr", busy, 1'b0);

        // Write 10, repeated START, read
        clear_mon();
        tx_data = 8'h55;
        i2c_start();
        write_byte(8'h84, ack); check("rs_waddr_ack", ack, 1'b0);
        write_byte(8'h10, ack); check("rs_data_ack", ack, 1'b0);
        i2c_start();
        write_byte(8'h85, ack); check("rs_raddr_ack", ack, 1'b0);
        wait_clk(Q);
        check("rs_tx_req_count", tx_cnt, 1);
        check("rs_no_stop", stop_cnt, 0);
        check("rs_rx_count", rx_q.size(), 1);
        check("rs_rx0", rx_q[0], {1'b1, 8'h10});
        i2c_byte(8'hFF, -1, rd); check("rs_rbyte", rd, 8'h55);
        i2c_bit(1'b1, 1'b0, ack);
        i2c_stop();

        // Reset while ACKing the address
        clear_mon();
        i2c_start();
        i2c_byte(8'h84, -1, rd);
        tb_sda_low = 1'b0;
        wait_clk(Q - 1);
        check("rr_sda_acking", sda_bus, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rr_sda_released", sda_bus, 1'b1);
        check("rr_busy", busy, 1'b0);
        check("rr_outputs", {rx_data, rx_valid, rx_first, tx_req, stop_det}, 12'h000);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        clear_mon();
        i2c_start();
        write_byte(8'h84, ack); check("rr_addr_ack", ack, 1'b0);
        i2c_stop();
        check("rr_stop_count", stop_cnt, 1);

        // SCL low glitch during the first data bit
        clear_mon();
        i2c_start();
        write_byte(8'h84, ack); check("g_addr_ack", ack, 1'b0);
        i2c_byte(8'hA5, 7, rd);
        i2c_bit(1'b1, 1'b0, ack);
        i2c_stop();
        check("g_rx_count", rx_q.size(), 1);
`ifdef I2C_TGT_FILTER_EN
        check("g_rx_filtered", rx_q[0], {1'b1, 8'hA5});
`else
        check("g_rx_corrupt", rx_q[0], {1'b1, 8'hD2});
`endif
        check("all_rx_stop_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
